// File: rtl/bin2bcd_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq_if
//  Description : Handshake/data bundle for the sequential binary-to-BCD
//                converter.
//                  start   - conversion request (master -> slave)
//                  bin_in  - unsigned binary operand, BIN_W bits (master -> slave)
//                  busy    - converter occupied (SHIFT or DONE)
//                  done    - one-cycle result-valid pulse
//                  bcd_out - packed BCD result, digit k at [4k+3:4k]
//                  ovf     - result did not fit in DIGITS digits
//  Revision    : 1.0 - initial release
// ============================================================================
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  ovf;

    // Requesting side: issues conversions and consumes results.
    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  bcd_out,
        input  ovf
    );

    // Converter side.
    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output bcd_out,
        output ovf
    );
endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential binary-to-BCD converter using shift-and-add-3
//                (double dabble), one input bit per clock.
//                A conversion takes BIN_W shift cycles plus one DONE cycle;
//                the previous result is held on bcd_out/ovf until the next
//                conversion completes.
//  Ports       : clk    - rising-edge clock
//                rst_n  - synchronous active-low reset
//                bus    - bin2bcd_seq_if.slave (start, bin_in, busy, done,
//                         bcd_out, ovf)
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    bin2bcd_seq_if.slave      bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                 c_cnt_w    = $clog2(BIN_W + 1);
    localparam int                 c_bcd_w    = 4 * DIGITS;
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(BIN_W);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    logic [BIN_W-1:0]       r_bin;      // binary bits still to be shifted in
    logic [c_bcd_w-1:0]     r_scr;      // BCD scratch accumulating the result
    logic [c_cnt_w-1:0]     r_cnt;      // shifts remaining
    logic                   r_ovf_int;  // sticky: a 1 left the top scratch digit
    logic [c_bcd_w-1:0]     r_bcd;      // published result
    logic                   r_ovf;      // published overflow

    // ------------------------------------------------------------------------
    // Control strobes from the FSM
    // ------------------------------------------------------------------------
    logic                   w_load;     // accept a new conversion
    logic                   w_shift;    // perform one adjust+shift step
    logic                   w_last;     // this step is the final one

    // ------------------------------------------------------------------------
    // Combinational shift step
    // ------------------------------------------------------------------------
    logic [c_bcd_w-1:0]     w_adj;      // scratch after add-3 correction
    logic [c_bcd_w-1:0]     w_scr_nxt;  // scratch after the shift
    logic [BIN_W-1:0]       w_bin_nxt;  // binary register after the shift
    logic                   w_ovf_nxt;  // overflow flag after the shift

    // Every digit is corrected in parallel. A digit of 5..9 becomes 8..12, so
    // after the left shift it carries exactly into the next digit and the
    // remaining value is again a legal 0..9 digit.
    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        assign w_adj[4*k +: 4] = (r_scr[4*k +: 4] >= 4'd5)
                               ? (r_scr[4*k +: 4] + 4'd3)
                               : r_scr[4*k +: 4];
    end

    // The MSB of the binary register feeds the LSB of the scratch register.
    // Whatever falls out of the top scratch digit is a digit beyond DIGITS,
    // so any 1 seen there means the true value did not fit.
    assign w_scr_nxt = {w_adj[c_bcd_w-2:0], r_bin[BIN_W-1]};
    assign w_ovf_nxt = r_ovf_int | w_adj[c_bcd_w-1];

    // A one-bit input has nothing left behind it after the shift.
    if (BIN_W == 1) begin : g_bin_one
        assign w_bin_nxt = 1'b0;
    end else begin : g_bin_wide
        assign w_bin_nxt = {r_bin[BIN_W-2:0], 1'b0};
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_last      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // start is only looked at here, so requests made while busy
                // are simply dropped.
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                w_shift = 1'b1;
                // r_cnt counts shifts still owed; reaching 1 means this edge
                // performs the BIN_W-th and final shift.
                if (r_cnt == c_cnt_one) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bin     <= '0;
            r_scr     <= '0;
            r_cnt     <= '0;
            r_ovf_int <= 1'b0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_load) begin
                r_bin     <= bus.bin_in;
                r_scr     <= '0;
                r_ovf_int <= 1'b0;
                r_cnt     <= c_cnt_load;
            end else if (w_shift) begin
                r_bin     <= w_bin_nxt;
                r_scr     <= w_scr_nxt;
                r_ovf_int <= w_ovf_nxt;
                r_cnt     <= r_cnt - c_cnt_one;
            end

            // Publish on the same edge that enters DONE so the result is
            // already valid during the done pulse.
            if (w_last) begin
                r_bcd <= w_scr_nxt;
                r_ovf <= w_ovf_nxt;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: all decoded straight from registers
    // ------------------------------------------------------------------------
    assign bus.busy    = (r_state != ST_IDLE);
    assign bus.done    = (r_state == ST_DONE);
    assign bus.bcd_out = r_bcd;
    assign bus.ovf     = r_ovf;

endmodule
`default_nettype wire

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock.
- Produces packed BCD digits that directly feed the downstream single-digit BCD adder (digit slices of bcd_out go straight to its 4-bit A/B operands).
- Start/busy/done handshake; the last result is held stable until the next conversion completes.

Parameters:
- BIN_W, 8: width of the binary input, in bits; legal range 1 or more.
- DIGITS, 3: number of BCD output digits; legal range 1 or more. Undersizing is legal and is reported via ovf.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request a conversion; sampled only in IDLE.
- bin_in  input  BIN_W  unsigned binary value; captured on the accepted start edge only.
- busy  output  1  high in SHIFT and DONE states.
- done  output  1  one-cycle pulse; bcd_out/ovf are valid for the new result from this cycle on.
- bcd_out  output  4*DIGITS  packed BCD; digit k occupies bits [4k+3:4k], with digit 0 the least significant.
- ovf  output  1  the result needed more than DIGITS digits; bcd_out then holds the low DIGITS digits of the true value.

Behaviour:
- Reset (rst_n low at a rising edge), from any state:
  - state to IDLE, with busy=0, done=0, bcd_out=0, ovf=0.
  - Internal shift register and bit counter cleared.
  - A conversion in progress is aborted, no done pulse is issued, and nothing is written to bcd_out.
- FSM has 3 states: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1 at edge N: capture bin_in into the binary shift register, clear the BCD scratch register and the internal overflow flag, load cnt=BIN_W, then go to SHIFT.
  - If start=0, remain in IDLE.
- SHIFT, once per edge:
  1. For every scratch digit that is 5 or more, add 3. All digits are adjusted in parallel, in the same cycle.
  2. Shift the concatenation {scratch, binary} left by 1.
  3. If the bit shifted out of the top scratch digit is 1, set the internal overflow flag (sticky for this conversion).
  4. Decrement cnt. When this edge performs the BIN_W-th shift, go to DONE.
- DONE:
  - Entered at edge N+BIN_W. On that same edge, the scratch register is copied to bcd_out and the internal flag to ovf.
  - done=1 for exactly that one cycle; the next edge returns to IDLE, with done=0 and busy=0.
- Latency:
  - done is high in the cycle following edge N+BIN_W.
  - A new start is accepted at edge N+BIN_W+2 at the earliest, giving a throughput of one conversion per BIN_W+2 cycles.
- start while busy=1 (SHIFT or DONE) is ignored: it is neither queued nor does it recapture bin_in.
- bin_in changes after the accepted start edge have no effect on the conversion in progress.
- bcd_out and ovf hold the previous result throughout SHIFT. They change only on DONE entry or reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Every digit of bcd_out is always in the range 0–9.

Test Plan:
- Default parameters, reset, then bin_in=8'd255 with start pulsed at edge N:
  - busy=1 from N+1.
  - done=1 only in the cycle after edge N+8.
  - bcd_out=12'h255, ovf=0.
  - Back in IDLE at N+9 with busy=0.
- Back-to-back conversions of 0, 19 and 99:
  - bcd_out=12'h000, 12'h019 and 12'h099 in turn.
  - bcd_out holds 12'h019 during every SHIFT cycle of the 99 conversion.
- Conversion of 8'd128 started, then start=1 with bin_in=8'd7 driven during SHIFT and DONE:
  - Result is 12'h128.
  - Exactly one done pulse.
  - The new request is not latched.
- Conversion of 8'd200, with rst_n low for one edge at shift 4, then released:
  - No done pulse; bcd_out=0, ovf=0.
  - A subsequent conversion of 8'd42 gives 12'h042.
- DIGITS=2, BIN_W=8:
  - bin_in=99 gives 8'h99, ovf=0.
  - bin_in=150 gives 8'h50, ovf=1.
  - bin_in=100 gives 8'h00, ovf=1.
- BIN_W=4, DIGITS=2, sweep bin_in 0..15:
  - Each result equals the decimal value, e.g. 9 gives 8'h09 and 15 gives 8'h15.
  - done arrives 4 cycles after start.
  - Each low digit, fed with another digit to the BCD adder, yields a correct sum.
